// File: rtl/pwm_capture.sv
// PWM decoder: measures cycle length and high time between rising edges of an
// asynchronous input and publishes them in the generator's period/width encoding.
module pwm_capture #(
  parameter  int BITS        = 24,
  parameter  int SYNC_STAGES = 2,
  localparam int CW          = BITS + 2
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          pwm_in,
  output logic [CW-1:0] period,
  output logic [CW-1:0] width,
  output logic          valid,
  output logic          timeout,
  output logic          stuck_level
);

  // state     | meaning
  // WAIT_LOW  | input must be seen low before arming (no edge from a high reset level)
  // WAIT_RISE | armed, first rise starts the first full cycle
  // MEASURE   | every rise closes a cycle and publishes period/width
  typedef enum logic [1:0] {
    WAIT_LOW  = 2'd0,
    WAIT_RISE = 2'd1,
    MEASURE   = 2'd2
  } state_t;

  localparam logic [CW-1:0] MAX = '1;

  logic [SYNC_STAGES-1:0] sync;
  logic [SYNC_STAGES-1:0] fill;
  logic                   s;
  logic                   s_d;
  logic                   rise;
  logic                   primed;
  logic                   fire;
  logic                   publish;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          hcnt;
  state_t                 state;
  state_t                 state_nxt;

  assign s      = sync[SYNC_STAGES-1];
  assign rise   = s & ~s_d;
  assign fire   = (cnt == MAX) && !rise;
  // The synchronizer holds reset zeros for SYNC_STAGES cycles; a low seen
  // before it refills would let a high input fake a rising edge.
  assign primed = fill[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!nreset) begin
      sync <= '0;
      fill <= '0;
      s_d  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pwm_in};
      fill <= {fill[SYNC_STAGES-2:0], 1'b1};
      s_d  <= s;
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset || rise || fire) begin
      cnt <= '0;
    end else if (cnt != MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      hcnt <= '0;
    end else if (rise) begin
      hcnt <= CW'(1);
    end else if (s && (hcnt != MAX)) begin
      hcnt <= hcnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state <= WAIT_LOW;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    publish   = 1'b0;
    if (fire) begin
      state_nxt = s ? WAIT_LOW : WAIT_RISE;
    end else begin
      case (state)
        WAIT_LOW:  if (primed && !s) state_nxt = WAIT_RISE;
        WAIT_RISE: if (rise) state_nxt = MEASURE;
        MEASURE:   if (rise) publish = 1'b1;
        default:   state_nxt = WAIT_LOW;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      period      <= '0;
      width       <= '0;
      valid       <= 1'b0;
      timeout     <= 1'b0;
      stuck_level <= 1'b0;
    end else begin
      valid <= publish;
      if (publish) begin
        period  <= cnt;
        width   <= hcnt;
        timeout <= 1'b0;
      end else if (fire) begin
        timeout     <= 1'b1;
        stuck_level <= s;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture at BITS=6 (CW=8, MAX=255), SYNC_STAGES=2.
module tb_pwm_capture;

  logic       clk;
  logic       nreset;
  logic       pwm_in;
  logic [7:0] period;
  logic [7:0] width;
  logic       valid;
  logic       timeout;
  logic       stuck_level;

  int n_cmp  = 0;
  int n_err  = 0;
  int nvalid = 0;
  bit check_on = 0;
  int exp_p = 0;
  int exp_w = 0;

  pwm_capture #(.BITS(6), .SYNC_STAGES(2)) dut (
    .clk(clk),
    .nreset(nreset),
    .pwm_in(pwm_in),
    .period(period),
    .width(width),
    .valid(valid),
    .timeout(timeout),
    .stuck_level(stuck_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // one clock; any valid seen is checked against the current expectation
  task automatic tick();
    @(posedge clk);
    #1;
    if (valid) begin
      nvalid++;
      if (check_on) begin
        chk("period_at_valid", {24'd0, period}, exp_p);
        chk("width_at_valid", {24'd0, width}, exp_w);
        chk("timeout_at_valid", {31'd0, timeout}, 0);
      end
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_cycle(input int h, input int l);
    pwm_in = 1'b1;
    ticks(h);
    pwm_in = 1'b0;
    ticks(l);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_period"}, {24'd0, period}, 0);
    chk({tag, "_width"}, {24'd0, width}, 0);
    chk({tag, "_valid"}, {31'd0, valid}, 0);
    chk({tag, "_timeout"}, {31'd0, timeout}, 0);
    chk({tag, "_stuck"}, {31'd0, stuck_level}, 0);
  endtask

  initial begin
    int w;
    nreset = 1'b0;
    pwm_in = 1'b0;
    ticks(4);
    chk_zero("reset");
    nreset = 1'b1;
    ticks(3);

    // 3 high / 7 low: first rise only arms
    exp_p = 9; exp_w = 3; check_on = 1;
    nvalid = 0;
    for (int i = 0; i < 6; i++) run_cycle(3, 7);
    chk("valids_3_7", nvalid, 5);

    // stuck low: fires 259 ticks after the last pwm high drive
    w = 0;
    while (!timeout && w < 400) begin tick(); w++; end
    chk("to_low_latency", w, 249);
    chk("to_low_stuck", {31'd0, stuck_level}, 0);
    chk("to_low_period", {24'd0, period}, 9);
    chk("to_low_width", {24'd0, width}, 3);
    chk("to_low_valid", {31'd0, valid}, 0);

    // resume: one arming cycle, timeout held until the next valid
    nvalid = 0;
    run_cycle(3, 7);
    chk("rearm_timeout_held", {31'd0, timeout}, 1);
    chk("rearm_no_valid", nvalid, 0);
    run_cycle(3, 7);
    run_cycle(3, 7);
    chk("rearm_valids", nvalid, 2);
    chk("rearm_timeout_clr", {31'd0, timeout}, 0);

    // 100% duty: the rise still closes a 9/3 cycle, then stuck high
    pwm_in = 1'b1;
    w = 0;
    while (!timeout && w < 400) begin tick(); w++; end
    chk("to_high_latency", w, 259);
    chk("to_high_stuck", {31'd0, stuck_level}, 1);
    chk("to_high_period", {24'd0, period}, 9);
    chk("to_high_width", {24'd0, width}, 3);

    // minimum phases after waiting for a low
    pwm_in = 1'b0;
    ticks(2);
    exp_p = 1; exp_w = 1;
    nvalid = 0;
    for (int i = 0; i < 10; i++) run_cycle(1, 1);
    ticks(4);
    chk("valids_1_1", nvalid, 9);
    chk("min_timeout_clr", {31'd0, timeout}, 0);

    // reset pulse in the middle of a cycle
    check_on = 0;
    run_cycle(3, 7);
    run_cycle(3, 7);
    pwm_in = 1'b1;
    ticks(3);
    pwm_in = 1'b0;
    ticks(2);
    nreset = 1'b0;
    tick();
    chk_zero("midreset");
    nreset = 1'b1;
    nvalid = 0;
    ticks(5);
    chk("midreset_no_valid", nvalid, 0);
    exp_p = 9; exp_w = 3; check_on = 1;
    for (int i = 0; i < 3; i++) run_cycle(3, 7);
    chk("midreset_valids", nvalid, 2);

    // input high across reset release, falls 5 clocks later, then 4/4
    nreset = 1'b0;
    pwm_in = 1'b1;
    ticks(3);
    nreset = 1'b1;
    nvalid = 0;
    exp_p = 7; exp_w = 4;
    ticks(5);
    pwm_in = 1'b0;
    ticks(4);
    chk("highrst_no_valid", nvalid, 0);
    for (int i = 0; i < 4; i++) run_cycle(4, 4);
    chk("highrst_valids", nvalid, 3);

    // generator loopback: period=20, width=7 -> 7 high / 14 low
    check_on = 0;
    run_cycle(7, 14);
    exp_p = 20; exp_w = 7; check_on = 1;
    nvalid = 0;
    for (int i = 0; i < 3; i++) run_cycle(7, 14);
    chk("loop_valids", nvalid, 3);
    // generator width=0: constant low
    w = 0;
    while (!timeout && w < 400) begin tick(); w++; end
    chk("loop_to_latency", w, 238);
    chk("loop_to_stuck", {31'd0, stuck_level}, 0);
    chk("loop_to_period", {24'd0, period}, 20);
    chk("loop_to_width", {24'd0, width}, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
